servo_pulse_decoder: RTL and testbench
======================================

Name: servo_pulse_decoder

Overview:
Receive side of the hobby-servo PWM interface: measures the high time of an incoming servo/RC pulse train in microseconds, using the same 20 ms frame convention as our servo generator. Sits between an RC receiver input pin and logic that consumes `pulse_len`, typically a servo generator or a CPU register. Also reports frame period, out-of-range pulses and loss of signal, with a neutral failsafe value.

Parameters:
- CLK_F, 25, clk frequency in MHz; cycles per microsecond tick.
- MIN_US, 500, shortest accepted pulse (µs).
- MAX_US, 2500, longest accepted pulse (µs).
- NEUTRAL_US, 1500, `pulse_len` value after reset and on signal loss.
- TIMEOUT_US, 25000, µs without a rising edge before `signal_lost`.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- pwm_in  input  1  asynchronous servo pulse input
- pulse_len  output  16  last accepted high time, µs
- pulse_valid  output  1  one-cycle strobe: `pulse_len` just updated
- period  output  16  last measured rise-to-rise time, µs (saturating)
- range_err  output  1  one-cycle strobe: pulse rejected
- signal_lost  output  1  level: no rising edge for TIMEOUT_US

Behaviour:
- Reset (async) values: `pulse_len`=NEUTRAL_US, `pulse_valid`=0, `period`=0, `range_err`=0, `signal_lost`=1, state=S_ARM, all counters 0.
- Input synchronisation:
  - `pwm_in` passes through a 2-flop synchroniser, then one delay flop.
  - rise = sync & ~dly; fall = ~sync & dly.
- Microsecond tick:
  - Prescaler counts 0..CLK_F-1; tick fires when prescaler == CLK_F-1.
  - Prescaler is forced to 0 on every detected rise, so width is phase-exact.
- Counters (16 bit, saturate at 0xFFFF, never wrap):
  - `hi_cnt` counts ticks while in S_HIGH.
  - `per_cnt` counts ticks since the last rise (or since reset/arm).
  - Both are cleared on rise.
- Width rule: a high time of exactly N*CLK_F clk cycles yields N. Truncate, never round: N*CLK_F-1 cycles yields N-1.
- State machine:
  - S_ARM: wait for sync==0, then go to S_IDLE. Prevents measuring a partial pulse after reset or abort.
  - S_IDLE:
    - On rise, go to S_HIGH.
    - If `have_rise` is set, load `period` <= `per_cnt`.
    - Set `have_rise`; clear counters and prescaler.
  - S_HIGH, on fall, go to S_IDLE:
    - If MIN_US ≤ `hi_cnt` ≤ MAX_US: `pulse_len` <= `hi_cnt`, `pulse_valid`=1 for one cycle, `signal_lost` <= 0.
    - Otherwise `range_err`=1 for one cycle; `pulse_len` unchanged.
  - S_HIGH, stuck-high abort: if `hi_cnt` reaches MAX_US+1, `range_err` strobes, `have_rise` is cleared and the FSM goes to S_ARM. A later fall in S_ARM produces no output.
- Timeout:
  - When `per_cnt` reaches TIMEOUT_US in any state: `signal_lost` <= 1, `pulse_len` <= NEUTRAL_US, `have_rise` <= 0.
  - Fires once; `per_cnt` saturates thereafter.
  - `period` holds its last value.
- Latency: the output strobe is registered. `pulse_valid`/`range_err` assert 3 clk cycles after the first clk edge that samples `pwm_in` low.
- Simultaneous events: timeout and fall in the same cycle resolve as follows.
  - Valid pulse wins: `signal_lost` ends at 0, `pulse_len` = measured value.
  - Invalid pulse: timeout effects apply.
- Reset mid-pulse returns to S_ARM: a pulse already high at release is ignored.

Decomposition:
- Shared package `servo_pkg`:
  - localparams FRAME_US=20000 and NEUTRAL_US=1500.
  - Default MIN_US/MAX_US.
  - State typedef {S_ARM, S_IDLE, S_HIGH}.
  - The servo generator uses the same constants.
- One natural sub-module, `sync_edge`: 2-flop synchroniser plus rise/fall detect. It is reused for other external inputs.

Test Plan:
- 1500 µs high, 20 ms period, 3 frames (CLK_F=25) → `pulse_len`=1500, one-cycle `pulse_valid` each frame, `period`=20000 from second frame, `signal_lost` 0 after first pulse.
- High for 1500*25-1 cycles → `pulse_len`=1499 (truncation); 500 µs and 2500 µs pulses accepted exactly at bounds.
- 300 µs pulse after a valid 1200 µs pulse → `range_err` strobe, `pulse_len` stays 1200, no `pulse_valid`.
- Input held high 5 ms → `range_err` at 2501 µs, no output on the later fall, next clean 1800 µs pulse → `pulse_len`=1800 and no `period` update on that rise.
- Valid pulses then input held low 30 ms → `signal_lost`=1 at 25000 µs after last rise, `pulse_len`=1500; next valid 1000 µs pulse clears `signal_lost`.
- `reset` asserted mid-pulse with `pwm_in` high → outputs return to reset values immediately; that pulse's fall gives no strobe; next full pulse measured correctly.

Source files
------------

// File: rtl/servo_pkg.sv
// Constants and types shared by the hobby-servo PWM generator and decoder.
package servo_pkg;

  localparam int unsigned CNT_W          = 16;
  localparam int unsigned FRAME_US       = 20000;
  localparam int unsigned NEUTRAL_US     = 1500;
  localparam int unsigned MIN_US_DEF     = 500;
  localparam int unsigned MAX_US_DEF     = 2500;
  localparam int unsigned TIMEOUT_US_DEF = 25000;
  localparam int unsigned CLK_F_DEF      = 25;

  typedef enum logic [1:0] {
    S_ARM,
    S_IDLE,
    S_HIGH
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous input, plus registered rise/fall strobes.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_dly;
  logic r_rise;
  logic r_fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_dly  <= RST_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_dly  <= r_sync;
      r_rise <= r_sync & ~r_dly;
      r_fall <= ~r_sync & r_dly;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/servo_pulse_decoder.sv
// Measures servo/RC pulse high time and frame period in microseconds,
// flags out-of-range pulses and loss of signal with a neutral failsafe.
module servo_pulse_decoder
  import servo_pkg::*;
#(
  parameter int unsigned CLK_F      = servo_pkg::CLK_F_DEF,
  parameter int unsigned MIN_US     = servo_pkg::MIN_US_DEF,
  parameter int unsigned MAX_US     = servo_pkg::MAX_US_DEF,
  parameter int unsigned NEUTRAL_US = servo_pkg::NEUTRAL_US,
  parameter int unsigned TIMEOUT_US = servo_pkg::TIMEOUT_US_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] pulse_len,
  output logic             pulse_valid,
  output logic [CNT_W-1:0] period,
  output logic             range_err,
  output logic             signal_lost
);

  localparam int unsigned PRESC_W = (CLK_F > 1) ? $clog2(CLK_F) : 1;

  logic               w_sync;
  logic               w_rise;
  logic               w_fall;
  logic               w_tick;
  logic               w_timeout;
  logic               w_in_range;
  logic               w_abort;
  logic [CNT_W-1:0]   w_hi_eff;
  logic [CNT_W-1:0]   w_per_eff;

  logic [PRESC_W-1:0] r_presc;
  logic [CNT_W-1:0]   r_hi_cnt;
  logic [CNT_W-1:0]   r_per_cnt;
  logic [CNT_W-1:0]   r_pulse_len;
  logic [CNT_W-1:0]   r_period;
  logic               r_pulse_valid;
  logic               r_range_err;
  logic               r_signal_lost;
  logic               r_have_rise;
  state_e             r_state;

  // Synchroniser resets to "high" so a pulse in progress at reset release
  // cannot produce a spurious rise; the FSM waits in S_ARM for a real low.
  sync_edge #(
    .RST_VAL (1'b1)
  ) u_sync_edge (
    .clk     (clk),
    .reset   (reset),
    .i_async (pwm_in),
    .o_sync  (w_sync),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // Microsecond prescaler, re-phased on every rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
    end else if (w_rise || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PRESC_W'(1);
    end
  end

  assign w_tick = (r_presc == PRESC_W'(CLK_F - 1));

  // Counter values including this cycle's tick, so N*CLK_F cycles reads as N.
  assign w_hi_eff   = w_tick ? sat_inc(r_hi_cnt)  : r_hi_cnt;
  assign w_per_eff  = w_tick ? sat_inc(r_per_cnt) : r_per_cnt;

  assign w_timeout  = w_tick && (r_per_cnt == CNT_W'(TIMEOUT_US - 1));
  assign w_in_range = (w_hi_eff >= CNT_W'(MIN_US)) && (w_hi_eff <= CNT_W'(MAX_US));
  assign w_abort    = (w_hi_eff == CNT_W'(MAX_US + 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_ARM;
      r_pulse_len   <= CNT_W'(NEUTRAL_US);
      r_pulse_valid <= 1'b0;
      r_period      <= '0;
      r_range_err   <= 1'b0;
      r_signal_lost <= 1'b1;
      r_have_rise   <= 1'b0;
      r_hi_cnt      <= '0;
      r_per_cnt     <= '0;
    end else begin
      r_pulse_valid <= 1'b0;
      r_range_err   <= 1'b0;
      r_per_cnt     <= w_per_eff;

      if (r_state == S_HIGH) begin
        r_hi_cnt <= w_hi_eff;
      end

      if (w_rise) begin
        r_hi_cnt  <= '0;
        r_per_cnt <= '0;
      end

      // Timeout first; a valid pulse ending in the same cycle overrides it below.
      if (w_timeout) begin
        r_signal_lost <= 1'b1;
        r_pulse_len   <= CNT_W'(NEUTRAL_US);
        r_have_rise   <= 1'b0;
      end

      case (r_state)
        S_ARM: begin
          if (!w_sync) begin
            r_state <= S_IDLE;
          end
        end

        S_IDLE: begin
          if (w_rise) begin
            r_state     <= S_HIGH;
            r_have_rise <= 1'b1;
            if (r_have_rise) begin
              r_period <= w_per_eff;
            end
          end
        end

        S_HIGH: begin
          if (w_fall) begin
            r_state <= S_IDLE;
            if (w_in_range) begin
              r_pulse_len   <= w_hi_eff;
              r_pulse_valid <= 1'b1;
              r_signal_lost <= 1'b0;
            end else begin
              r_range_err <= 1'b1;
            end
          end else if (w_abort) begin
            r_range_err <= 1'b1;
            r_have_rise <= 1'b0;
            r_state     <= S_ARM;
          end
        end

        default: begin
          r_state <= S_ARM;
        end
      endcase
    end
  end

  assign pulse_len   = r_pulse_len;
  assign pulse_valid = r_pulse_valid;
  assign period      = r_period;
  assign range_err   = r_range_err;
  assign signal_lost = r_signal_lost;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Directed bench for servo_pulse_decoder; CLK_F=2 and a 4 ms timeout keep the run short.
module tb_servo_pulse_decoder;

  localparam int unsigned CLK_F      = 2;
  localparam int unsigned MIN_US     = 500;
  localparam int unsigned MAX_US     = 2500;
  localparam int unsigned NEUTRAL_US = 1500;
  localparam int unsigned TIMEOUT_US = 4000;

  logic        clk;
  logic        reset;
  logic        pwm_in;
  logic [15:0] pulse_len;
  logic        pulse_valid;
  logic [15:0] period;
  logic        range_err;
  logic        signal_lost;

  int unsigned n_total;
  int unsigned n_bad;

  servo_pulse_decoder #(
    .CLK_F      (CLK_F),
    .MIN_US     (MIN_US),
    .MAX_US     (MAX_US),
    .NEUTRAL_US (NEUTRAL_US),
    .TIMEOUT_US (TIMEOUT_US)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pwm_in      (pwm_in),
    .pulse_len   (pulse_len),
    .pulse_valid (pulse_valid),
    .period      (period),
    .range_err   (range_err),
    .signal_lost (signal_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Starts and ends on a negedge; occupies hi_cyc + 5 clock cycles.
  task automatic send_pulse(input string tag, input int hi_cyc,
                            input bit exp_valid, input bit exp_rng, input int unsigned exp_len);
    pwm_in = 1'b1;
    repeat (hi_cyc) @(negedge clk);
    pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val({tag, "_early"}, 32'({pulse_valid, range_err}), 0);
    @(posedge clk);
    #1;
    check_val({tag, "_valid"}, 32'(pulse_valid), 32'(exp_valid));
    check_val({tag, "_rng"}, 32'(range_err), 32'(exp_rng));
    check_val({tag, "_len"}, 32'(pulse_len), exp_len);
    @(posedge clk);
    #1;
    check_val({tag, "_strobe_end"}, 32'({pulse_valid, range_err}), 0);
    @(negedge clk);
  endtask

  task automatic quiet(input string tag, input int n);
    bit seen;
    seen = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (pulse_valid || range_err) seen = 1'b1;
    end
    check_val(tag, 32'(seen), 0);
    @(negedge clk);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset   = 1'b1;
    pwm_in  = 1'b0;

    repeat (3) @(negedge clk);
    check_val("rst_len", 32'(pulse_len), 1500);
    check_val("rst_valid", 32'(pulse_valid), 0);
    check_val("rst_period", 32'(period), 0);
    check_val("rst_rng", 32'(range_err), 0);
    check_val("rst_lost", 32'(signal_lost), 1);
    reset = 1'b0;
    gap(10);

    // 1500 us pulses in 3000 us frames
    send_pulse("f1", 3000, 1, 0, 1500);
    check_val("f1_period", 32'(period), 0);
    check_val("f1_lost", 32'(signal_lost), 0);
    gap(2995);
    send_pulse("f2", 3000, 1, 0, 1500);
    check_val("f2_period", 32'(period), 3000);
    gap(2995);
    send_pulse("f3", 3000, 1, 0, 1500);
    check_val("f3_period", 32'(period), 3000);
    gap(300);

    // Truncation and range bounds
    send_pulse("trunc", 2999, 1, 0, 1499);
    gap(300);
    send_pulse("min", 1000, 1, 0, 500);
    check_val("min_period", 32'(period), 1652);
    gap(300);
    send_pulse("max", 5000, 1, 0, 2500);
    gap(300);
    send_pulse("max_trunc", 5001, 1, 0, 2500);
    gap(300);
    send_pulse("below_min", 999, 0, 1, 2500);
    gap(300);
    send_pulse("p1200", 2400, 1, 0, 1200);
    gap(300);
    send_pulse("short", 600, 0, 1, 1200);
    gap(300);

    // Stuck high: abort strobe once hi_cnt reaches 2501
    pwm_in = 1'b1;
    repeat (5005) @(posedge clk);
    #1;
    check_val("abort_pre", 32'(range_err), 0);
    @(posedge clk);
    #1;
    check_val("abort_rng", 32'(range_err), 1);
    check_val("abort_len", 32'(pulse_len), 1200);
    check_val("abort_period", 32'(period), 452);
    @(posedge clk);
    #1;
    check_val("abort_end", 32'(range_err), 0);
    repeat (1000) @(negedge clk);
    pwm_in = 1'b0;
    quiet("stuck_fall_quiet", 10);
    gap(300);
    send_pulse("p1800", 3600, 1, 0, 1800);
    check_val("p1800_period", 32'(period), 452);

    // Timeout 4000 us after the 1800 us pulse's rise
    repeat (4398) @(posedge clk);
    #1;
    check_val("to_pre_lost", 32'(signal_lost), 0);
    check_val("to_pre_len", 32'(pulse_len), 1800);
    @(posedge clk);
    #1;
    check_val("to_lost", 32'(signal_lost), 1);
    check_val("to_len", 32'(pulse_len), 1500);
    @(negedge clk);
    gap(500);
    send_pulse("p1000", 2000, 1, 0, 1000);
    check_val("p1000_lost", 32'(signal_lost), 0);
    check_val("p1000_period", 32'(period), 452);
    gap(300);

    // Reset while the input is high
    pwm_in = 1'b1;
    repeat (500) @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("mid_rst_len", 32'(pulse_len), 1500);
    check_val("mid_rst_lost", 32'(signal_lost), 1);
    check_val("mid_rst_period", 32'(period), 0);
    check_val("mid_rst_strobes", 32'({pulse_valid, range_err}), 0);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (500) @(negedge clk);
    pwm_in = 1'b0;
    quiet("rst_fall_quiet", 10);
    gap(300);
    send_pulse("after_rst", 3000, 1, 0, 1500);
    check_val("after_rst_lost", 32'(signal_lost), 0);
    check_val("after_rst_period", 32'(period), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
